// File: rtl/wb_retire.sv
// In-order write-back/retire queue sharing one register-file write port with a
// higher-priority external writer; also drives scoreboard pops and instret.
module wb_retire #(
  parameter  int XLEN  = 64,
  parameter  int DEPTH = 4,
  parameter  int NSRC  = 3,
  localparam int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_inst,
  input  logic                 in_regwr,
  input  logic [SELW-1:0]      in_regsrc,
  input  logic [NSRC*XLEN-1:0] in_srcdata,
  input  logic                 flush,
  input  logic                 ext_wen,
  input  logic [4:0]           ext_waddr,
  input  logic [XLEN-1:0]      ext_wdata,
  output logic                 rf_wen,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 witf_pop_en,
  output logic                 retire_valid,
  output logic [XLEN-1:0]      retire_pc,
  output logic [31:0]          retire_inst,
  output logic [63:0]          instret,
  output logic [CW-1:0]        q_count
);

  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [31:0]     r_inst  [DEPTH];
  logic [XLEN-1:0] r_wdata [DEPTH];
  logic            r_wen   [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [63:0]     r_instret;

  logic            w_full;
  logic            w_empty;
  logic            w_enq;
  logic            w_deq;
  logic            w_head_wen;
  logic            w_ext_ok;
  logic [4:0]      w_rd;
  logic            w_in_wen;
  logic [XLEN-1:0] w_sel_data;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_rd       = in_inst[11:7];
  assign w_in_wen   = in_regwr && (w_rd != 5'd0);
  assign w_head_wen = r_wen[r_rptr];

  assign in_ready   = !rst && !w_full;
  assign w_enq      = in_valid && in_ready && !flush;
  // An external write stalls only a head that also needs the write port.
  assign w_deq      = !rst && !w_empty && !flush && (!w_head_wen || !ext_wen);
  assign w_ext_ok   = !rst && ext_wen && (ext_waddr != 5'd0);

  // Source-slice select; out-of-range selectors fall back to slice 0.
  always_comb begin
    w_sel_data = in_srcdata[XLEN-1:0];
    for (int k = 0; k < NSRC; k++) begin
      if (in_regsrc == SELW'(k)) begin
        w_sel_data = in_srcdata[k*XLEN +: XLEN];
      end else begin
        w_sel_data = w_sel_data;
      end
    end
  end

  // Pointer, occupancy, write-enable flags and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_instret <= 64'd0;
      for (int i = 0; i < DEPTH; i++) r_wen[i] <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_wen[r_wptr] <= w_in_wen;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_deq) begin
        r_rptr    <= r_rptr + PW'(1);
        r_instret <= r_instret + 64'd1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload storage; contents are qualified by the pointers/flags above.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc[r_wptr]    <= in_pc;
      r_inst[r_wptr]  <= in_inst;
      r_wdata[r_wptr] <= w_sel_data;
    end
  end

  // Shared write-port mux and retire outputs.
  always_comb begin
    rf_wen       = 1'b0;
    rf_waddr     = 5'd0;
    rf_wdata     = '0;
    retire_valid = w_deq;
    witf_pop_en  = w_deq && w_head_wen;
    retire_pc    = '0;
    retire_inst  = 32'd0;
    if (w_ext_ok) begin
      rf_wen   = 1'b1;
      rf_waddr = ext_waddr;
      rf_wdata = ext_wdata;
    end else if (w_deq && w_head_wen) begin
      rf_wen   = 1'b1;
      rf_waddr = r_inst[r_rptr][11:7];
      rf_wdata = r_wdata[r_rptr];
    end else begin
      rf_wen = 1'b0;
    end
    if (w_deq) begin
      retire_pc   = r_pc[r_rptr];
      retire_inst = r_inst[r_rptr];
    end else begin
      retire_pc   = '0;
      retire_inst = 32'd0;
    end
  end

  assign instret = r_instret;
  assign q_count = r_count;

endmodule

// File: tb/tb_wb_retire.sv
// Randomised and directed bench for wb_retire against a queue-based reference model.
module tb_wb_retire;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int NSRC  = 3;
  localparam int SELW  = 2;
  localparam int CW    = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      in_pc;
  logic [31:0]          in_inst;
  logic                 in_regwr;
  logic [SELW-1:0]      in_regsrc;
  logic [NSRC*XLEN-1:0] in_srcdata;
  logic                 flush;
  logic                 ext_wen;
  logic [4:0]           ext_waddr;
  logic [XLEN-1:0]      ext_wdata;
  logic                 rf_wen;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 witf_pop_en;
  logic                 retire_valid;
  logic [XLEN-1:0]      retire_pc;
  logic [31:0]          retire_inst;
  logic [63:0]          instret;
  logic [CW-1:0]        q_count;

  wb_retire #(.XLEN(XLEN), .DEPTH(DEPTH), .NSRC(NSRC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_regwr(in_regwr),
    .in_regsrc(in_regsrc), .in_srcdata(in_srcdata), .flush(flush),
    .ext_wen(ext_wen), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .witf_pop_en(witf_pop_en), .retire_valid(retire_valid),
    .retire_pc(retire_pc), .retire_inst(retire_inst),
    .instret(instret), .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [63:0] wdata;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_instret;
  int          n_total = 0;
  int          n_bad   = 0;
  int          n_rf_writes = 0;
  int          n_pops = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive the upstream port; the instruction carries rd in [11:7].
  task automatic drv(input bit v, input bit wr, input logic [4:0] rd,
                     input logic [SELW-1:0] src, input logic [63:0] pc);
    in_valid  = v;
    in_regwr  = wr;
    in_inst   = {20'h00000, rd, 7'h33};
    in_regsrc = src;
    in_pc     = pc;
  endtask

  task automatic ext(input bit en, input logic [4:0] a, input logic [63:0] d);
    ext_wen   = en;
    ext_waddr = a;
    ext_wdata = d;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic cyc();
    bit          e_ready, e_ret, e_ext, head_wen;
    logic [63:0] sel;
    ent_t        e;
    #1;
    e_ready  = !rst && (mq.size() < DEPTH);
    head_wen = (mq.size() > 0) ? mq[0].wen : 1'b0;
    e_ret    = !rst && (mq.size() > 0) && !flush && (!head_wen || !ext_wen);
    e_ext    = !rst && ext_wen && (ext_waddr != 5'd0);
    chk("in_ready", in_ready, e_ready);
    chk("retire_valid", retire_valid, e_ret);
    chk("witf_pop_en", witf_pop_en, e_ret && head_wen);
    chk("rf_wen", rf_wen, e_ext || (e_ret && head_wen));
    chk("q_count", q_count, mq.size());
    chk("instret", instret, m_instret);
    if (e_ext) begin
      chk("rf_waddr_ext", rf_waddr, ext_waddr);
      chk("rf_wdata_ext", rf_wdata, ext_wdata);
    end else if (e_ret && head_wen) begin
      chk("rf_waddr_q", rf_waddr, mq[0].inst[11:7]);
      chk("rf_wdata_q", rf_wdata, mq[0].wdata);
    end
    if (e_ret) begin
      chk("retire_pc", retire_pc, mq[0].pc);
      chk("retire_inst", retire_inst, mq[0].inst);
    end
    if (rst) begin
      chk("rst_rf_waddr", rf_waddr, 64'd0);
      chk("rst_rf_wdata", rf_wdata, 64'd0);
    end
    if (rf_wen) n_rf_writes++;
    if (witf_pop_en) n_pops++;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_instret = 64'd0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (e_ret) begin
        void'(mq.pop_front());
        m_instret = m_instret + 64'd1;
      end
      if (in_valid && e_ready) begin
        sel = (in_regsrc < NSRC) ? 64'(in_srcdata >> (in_regsrc * XLEN)) : in_srcdata[63:0];
        e.pc    = in_pc;
        e.inst  = in_inst;
        e.wen   = in_regwr && (in_inst[11:7] != 5'd0);
        e.wdata = sel;
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drv(1'b0, 1'b0, 5'd0, 2'd0, 64'd0);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    m_instret = 64'd0;
    rst = 1'b1;
    flush = 1'b0;
    in_srcdata = '0;
    drv(1'b0, 1'b0, 5'd0, 2'd0, 64'd0);
    ext(1'b1, 5'd3, 64'h99);
    @(posedge clk);
    @(negedge clk);
    // Reset with an external write pending: nothing may reach the port.
    cyc();
    chk("rst_rf_wen", rf_wen, 1'b0);
    rst = 1'b0;
    ext(1'b0, 5'd0, 64'd0);
    idle(1);

    // Three back-to-back ALU writes.
    n_rf_writes = 0; n_pops = 0;
    for (int i = 0; i < 3; i++) begin
      in_srcdata = {64'hC0, 64'hB0, 64'(8'h11 * (i + 1))};
      drv(1'b1, 1'b1, 5'(i + 1), 2'd0, 64'h1000 + 64'(4 * i));
      cyc();
    end
    idle(4);
    chk("alu_instret", instret, 64'd3);
    chk("alu_writes", n_rf_writes, 3);
    chk("alu_pops", n_pops, 3);

    // Fill the queue while an external write blocks writing heads.
    ext(1'b1, 5'd9, 64'h77);
    for (int i = 0; i < 6; i++) begin
      in_srcdata = {64'hC0, 64'hB0, 64'h500 + 64'(i)};
      drv(1'b1, 1'b1, 5'(10 + i), 2'd0, 64'h2000 + 64'(4 * i));
      cyc();
    end
    chk("full_count", q_count, 3'd4);
    chk("full_ready", in_ready, 1'b0);
    ext(1'b0, 5'd0, 64'd0);
    idle(6);

    // Non-writing heads retire under an external write.
    drv(1'b1, 1'b1, 5'd0, 2'd0, 64'h3000); cyc();
    drv(1'b1, 1'b0, 5'd4, 2'd0, 64'h3004); cyc();
    drv(1'b0, 1'b0, 5'd0, 2'd0, 64'd0);
    ext(1'b1, 5'd5, 64'hAB);
    cyc(); cyc(); cyc();
    ext(1'b0, 5'd0, 64'd0);
    idle(2);

    // Flush with three queued entries and a concurrent external write.
    ext(1'b1, 5'd7, 64'h1);
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, 5'(20 + i), 2'd1, 64'h4000 + 64'(4 * i));
      cyc();
    end
    drv(1'b1, 1'b1, 5'd25, 2'd0, 64'h4100);
    flush = 1'b1;
    ext(1'b1, 5'd7, 64'h5);
    cyc();
    flush = 1'b0;
    ext(1'b0, 5'd0, 64'd0);
    chk("flush_count", q_count, 3'd0);
    drv(1'b1, 1'b1, 5'd26, 2'd0, 64'h4200); cyc();
    idle(2);

    // Source-slice selection, including an out-of-range selector.
    in_srcdata = {64'hDEAD, 64'hBEEF, 64'hF00D};
    drv(1'b1, 1'b1, 5'd8, 2'd2, 64'h5000); cyc();
    chk("src2_data", rf_wdata, 64'hDEAD);
    drv(1'b1, 1'b1, 5'd8, 2'd3, 64'h5004); cyc();
    chk("src3_data", rf_wdata, 64'hF00D);
    idle(2);

    // instret wrap from all-ones.
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    drv(1'b1, 1'b0, 5'd1, 2'd0, 64'h6000); cyc();
    idle(2);
    chk("instret_wrap", instret, 64'd0);

    // Reset with entries queued and an external write active.
    ext(1'b1, 5'd6, 64'h66);
    drv(1'b1, 1'b1, 5'd11, 2'd0, 64'h7000); cyc();
    drv(1'b1, 1'b1, 5'd12, 2'd0, 64'h7004); cyc();
    drv(1'b0, 1'b0, 5'd0, 2'd0, 64'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ext(1'b0, 5'd0, 64'd0);
    n_pops = 0;
    idle(3);
    chk("rst_no_pops", n_pops, 0);
    chk("rst_instret", instret, 64'd0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      in_srcdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), {$urandom, $urandom});
      ext($urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), {$urandom, $urandom});
      flush = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0; flush = 1'b0;
    ext(1'b0, 5'd0, 64'd0);
    idle(6);
    chk("drain_count", q_count, 3'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
